// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl
// Description : Reaction-timer round controller. It handles the random ARM
//               delay, the reaction count, false starts and the best time.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_ctrl #(
    parameter int MIN_DELAY = 1000,
    parameter int RT_MAX    = 9999
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        Start,
    input  logic        Stop,
    input  logic        tick_ms,
    input  logic [13:0] rand_val,
    output logic [2:0]  state,
    output logic        led_go,
    output logic        foul,
    output logic        timeout,
    output logic [13:0] disp_val,
    output logic [13:0] best
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_ARM  = 3'b001,
        S_TIME = 3'b010,
        S_DONE = 3'b011,
        S_FOUL = 3'b100
    } state_t;

    localparam logic [13:0] C_MIN_DELAY = 14'(MIN_DELAY);
    localparam logic [13:0] C_RT_MAX    = 14'(RT_MAX);
    localparam logic [13:0] C_RT_LAST   = 14'(RT_MAX - 1);

    state_t      state_q, state_d;
    logic [13:0] delay_q, delay_d;
    logic [13:0] rt_q, rt_d;
    logic [13:0] best_q, best_d;
    logic        timeout_q, timeout_d;

    logic        start_prev_q, stop_prev_q;
    logic        start_rel_q, stop_rel_q;

    logic        start_press;
    logic        stop_press;
    logic [13:0] load_delay;
    logic        rand_unused;

    // A button held low through clear must be released once before it can
    // produce a press, hence the release-seen qualifier next to prev.
    assign start_press = start_rel_q & start_prev_q & ~Start;
    assign stop_press  = stop_rel_q  & stop_prev_q  & ~Stop;

    assign load_delay  = C_MIN_DELAY + {2'b00, rand_val[11:0]};
    assign rand_unused = ^rand_val[13:12];

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= S_IDLE;
            delay_q      <= 14'd0;
            rt_q         <= 14'd0;
            best_q       <= C_RT_MAX;
            timeout_q    <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            start_rel_q  <= 1'b0;
            stop_rel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            rt_q         <= rt_d;
            best_q       <= best_d;
            timeout_q    <= timeout_d;
            start_prev_q <= Start;
            stop_prev_q  <= Stop;
            start_rel_q  <= start_rel_q | Start;
            stop_rel_q   <= stop_rel_q  | Stop;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        rt_d      = rt_q;
        best_d    = best_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    delay_d = load_delay;
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                if (stop_press) begin
                    state_d = S_FOUL;
                end else if (tick_ms) begin
                    if (delay_q != 14'd0) begin
                        delay_d = delay_q - 14'd1;
                    end
                    if (delay_q == 14'd1) begin
                        rt_d    = 14'd0;
                        state_d = S_TIME;
                    end
                end
            end

            S_TIME: begin
                if (stop_press) begin
                    state_d = S_DONE;
                    if (!timeout_q && (rt_q < best_q)) begin
                        best_d = rt_q;
                    end
                end else if (tick_ms) begin
                    // Saturate at RT_MAX; a timed-out round never updates best.
                    if (rt_q >= C_RT_LAST) begin
                        rt_d      = C_RT_MAX;
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        rt_d = rt_q + 14'd1;
                    end
                end
            end

            S_DONE: begin
                if (start_press) begin
                    delay_d   = load_delay;
                    timeout_d = 1'b0;
                    state_d   = S_ARM;
                end
            end

            S_FOUL: begin
                if (start_press) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state   = state_q;
    assign led_go  = (state_q == S_TIME);
    assign foul    = (state_q == S_FOUL);
    assign timeout = timeout_q;
    assign best    = best_q;

    always_comb begin
        disp_val = 14'd0;
        case (state_q)
            S_IDLE:         disp_val = best_q;
            S_TIME, S_DONE: disp_val = rt_q;
            default:        disp_val = 14'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_timer_ctrl
// Description : Scoreboard bench for reaction_timer_ctrl with a round model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] disp;
        logic [13:0] bst;
        logic        to;
        logic        go;
        logic        fl;
    } snap_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_TIME = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_FOUL = 3'd4;
    localparam int RTMAX = 9999;

    logic        clk = 1'b0;
    logic        clear;
    logic        Start;
    logic        Stop;
    logic        tick_ms;
    logic [13:0] rand_val;
    logic [2:0]  state;
    logic        led_go;
    logic        foul;
    logic        timeout;
    logic [13:0] disp_val;
    logic [13:0] best;

    reaction_timer_ctrl #(.MIN_DELAY(1000), .RT_MAX(RTMAX)) dut (
        .clk      (clk),
        .clear    (clear),
        .Start    (Start),
        .Stop     (Stop),
        .tick_ms  (tick_ms),
        .rand_val (rand_val),
        .state    (state),
        .led_go   (led_go),
        .foul     (foul),
        .timeout  (timeout),
        .disp_val (disp_val),
        .best     (best)
    );

    always #5 clk = ~clk;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    ev_idx   = 0;
    bit    mon_en   = 1'b0;
    bit    probe_r  = 1'b0;
    bit    end_req  = 1'b0;
    bit    done     = 1'b0;
    logic [2:0] last_state = 3'd0;
    int    m_best;

    // Monitor: an output event is a state change or an explicit probe.
    always @(negedge clk) begin
        snap_t act, e;
        act = '{st: state, disp: disp_val, bst: best, to: timeout, go: led_go, fl: foul};
        if (mon_en && ((state !== last_state) || probe_r)) begin
            checks++;
            ev_idx++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event#%0d got st=%0d disp=%0d best=%0d to=%0b go=%0b foul=%0b, none expected",
                         ev_idx, act.st, act.disp, act.bst, act.to, act.go, act.fl);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL event#%0d got st=%0d disp=%0d best=%0d to=%0b go=%0b foul=%0b want st=%0d disp=%0d best=%0d to=%0b go=%0b foul=%0b",
                             ev_idx, act.st, act.disp, act.bst, act.to, act.go, act.fl,
                             e.st, e.disp, e.bst, e.to, e.go, e.fl);
                end
            end
        end
        if (end_req && !done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL leftover_events got %0d pending want 0", exp_q.size());
            end
            done = 1'b1;
        end
        last_state = state;
    end

    function automatic snap_t mk(logic [2:0] st, int d, int b, bit to);
        snap_t s;
        s.st   = st;
        s.disp = 14'(d);
        s.bst  = 14'(b);
        s.to   = to;
        s.go   = (st == ST_TIME);
        s.fl   = (st == ST_FOUL);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        if ($urandom_range(0, 7) == 0) step();
    endtask

    task automatic press_start(bit with_stop);
        Start = 1'b0;
        if (with_stop) Stop = 1'b0;
        step();
        Start = 1'b1;
        Stop  = 1'b1;
        step();
    endtask

    task automatic press_stop(bit with_tick);
        Stop    = 1'b0;
        tick_ms = with_tick;
        step();
        Stop    = 1'b1;
        tick_ms = 1'b0;
        step();
    endtask

    task automatic probe(snap_t s);
        exp_q.push_back(s);
        probe_r = 1'b1;
        @(negedge clk);
        #1 probe_r = 1'b0;
        step();
    endtask

    // Start press, then the full random delay; TIME begins on the D-th tick.
    task automatic start_to_time(int r, bit with_stop);
        int d;
        rand_val = {2'($urandom), 12'(r)};
        d = 1000 + (r % 4096);
        exp_q.push_back(mk(ST_ARM, 0, m_best, 1'b0));
        press_start(with_stop);
        rand_val = 14'($urandom);
        for (int i = 1; i <= d; i++) begin
            if (i == d) exp_q.push_back(mk(ST_TIME, 0, m_best, 1'b0));
            tick();
        end
    endtask

    task automatic time_phase(int n, bit with_tick);
        for (int i = 0; i < n; i++) tick();
        if (n < m_best) m_best = n;
        exp_q.push_back(mk(ST_DONE, n, m_best, 1'b0));
        press_stop(with_tick);
    endtask

    task automatic foul_round(int r, int f, bit with_tick);
        rand_val = 14'(r);
        exp_q.push_back(mk(ST_ARM, 0, m_best, 1'b0));
        press_start(1'b0);
        for (int i = 1; i < f; i++) tick();
        exp_q.push_back(mk(ST_FOUL, 0, m_best, 1'b0));
        press_stop(with_tick);
        exp_q.push_back(mk(ST_IDLE, m_best, m_best, 1'b0));
        press_start(1'b0);
    endtask

    initial begin
        int r, n, f;
        bit sim;
        clear    = 1'b1;
        Start    = 1'b1;
        Stop     = 1'b1;
        tick_ms  = 1'b0;
        rand_val = 14'd0;
        m_best   = RTMAX;
        step(); step(); step();
        mon_en = 1'b1;
        step();
        clear = 1'b0;
        probe(mk(ST_IDLE, RTMAX, RTMAX, 1'b0));

        // Normal, worse and better rounds.
        start_to_time(0, 1'b0);
        time_phase(250, 1'b0);
        start_to_time($urandom_range(0, 4095), 1'b0);
        time_phase(300, 1'b0);
        start_to_time($urandom_range(0, 4095), 1'b0);
        time_phase(120, 1'b0);

        // Clear mid-round with Start held low and other inputs active.
        start_to_time(0, 1'b0);
        for (int i = 0; i < 77; i++) tick();
        m_best = RTMAX;
        exp_q.push_back(mk(ST_IDLE, RTMAX, RTMAX, 1'b0));
        clear = 1'b1; Start = 1'b0; Stop = 1'b0; tick_ms = 1'b1;
        step(); step();
        clear = 1'b0; Stop = 1'b1; tick_ms = 1'b0;
        step(); step(); step();
        probe(mk(ST_IDLE, RTMAX, RTMAX, 1'b0));
        Start = 1'b1;
        step();

        // Start and Stop together in IDLE count as Start only.
        start_to_time(0, 1'b1);
        time_phase(200, 1'b0);

        // False start with a same-cycle tick at the 500th ARM tick.
        foul_round(12'h0FF, 500, 1'b1);

        // Stop and tick together in TIME at rt=41.
        start_to_time(0, 1'b0);
        time_phase(41, 1'b1);

        // Timeout: 9999 ticks saturate; later ticks and Stop do nothing.
        start_to_time(0, 1'b0);
        for (int i = 0; i < RTMAX - 1; i++) tick();
        exp_q.push_back(mk(ST_DONE, RTMAX, m_best, 1'b1));
        tick();
        tick();
        press_stop(1'b0);
        probe(mk(ST_DONE, RTMAX, m_best, 1'b1));

        r = $urandom_range(0, 4095);
        f = $urandom_range(1, 999 + r);
        foul_round(r, f, 1'b0);

        for (int k = 0; k < 4; k++) begin
            r   = $urandom_range(0, 4095);
            n   = $urandom_range(1, 600);
            sim = 1'($urandom_range(0, 1));
            start_to_time(r, 1'b0);
            time_phase(n, sim);
            press_stop(1'b0);
        end
        probe(mk(ST_DONE, n, m_best, 1'b0));

        end_req = 1'b1;
        wait (done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog got no completion want completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
